// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_HOLD
  } op_e;

  // Ceiling log2 usable in constant expressions; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO of return addresses; a push while full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned PW       = clog2(RAS_DEPTH),
  localparam int unsigned CW       = clog2(RAS_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;

  // Pointer arithmetic wraps modulo the depth, which need not be a power of two.
  assign ptr_inc = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + PW'(1);
  assign ptr_dec = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);

  assign top   = mem[ptr];
  assign full  = (count == CW'(RAS_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CW'(1);
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/pc_ras.sv
// Program counter with load/increment/stall and CALL/RET through a return-address stack.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned   AW        = 16,
  parameter int unsigned   INC       = 1,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int unsigned   RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] din,
  input  logic          hold,
  input  logic          pcload,
  input  logic          pcinc,
  input  logic          call,
  input  logic          ret,
  input  logic          err_clr,
  output logic [AW-1:0] dout,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam int unsigned CW = clog2(RAS_DEPTH + 1);

  op_e           op;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_plus;
  logic [AW-1:0] stack_top;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          unf_set;

  assign pc_plus = dout + AW'(INC);

  ras_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top       (stack_top),
    .count     (stack_count),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign ras_empty = (stack_count == '0);
  assign ras_full  = (stack_count == CW'(RAS_DEPTH));

  // Only the highest-priority asserted operation is acted on.
  always_comb begin
    op = OP_IDLE;
    if (hold)        op = OP_HOLD;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (pcload) op = OP_LOAD;
    else if (pcinc)  op = OP_INC;
  end

  always_comb begin
    pc_next = dout;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_INC:  pc_next = pc_plus;
      OP_LOAD: pc_next = din;
      OP_CALL: begin
        push    = 1'b1;
        ovf_set = stack_full;
        pc_next = din;
      end
      OP_RET: begin
        // Return on an empty stack degrades to a plain advance.
        if (stack_empty) begin
          pc_next = pc_plus;
          unf_set = 1'b1;
        end else begin
          pc_next = stack_top;
          pop     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sticky error flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout    <= RESET_VEC;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      dout    <= pc_next;
      ras_ovf <= ovf_set | (ras_ovf & ~err_clr);
      ras_unf <= unf_set | (ras_unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// Self-checking bench for pc_ras: directed scenarios plus randomized traffic against a queue model.
module tb_pc_ras;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        hold, pcload, pcinc, call, ret, err_clr;
  logic [15:0] dout;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int n_cmp;
  int n_bad;

  // Reference model: PC value, return addresses (newest at back), sticky flags.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_ovf;
  logic        m_unf;

  pc_ras #(
    .AW        (16),
    .INC       (1),
    .RESET_VEC (16'h0000),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .hold      (hold),
    .pcload    (pcload),
    .pcinc     (pcinc),
    .call      (call),
    .ret       (ret),
    .err_clr   (err_clr),
    .dout      (dout),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] obs_vec();
    return {dout, ras_empty, ras_full, ras_ovf, ras_unf};
  endfunction

  function automatic logic [19:0] exp_vec();
    logic e, f;
    e = (m_q.size() == 0);
    f = (m_q.size() == DEPTH);
    return {m_pc, e, f, m_ovf, m_unf};
  endfunction

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic h, r, c, l, i, e, input logic [15:0] d);
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (!h) begin
      if (r) begin
        if (m_q.size() == 0) begin
          m_pc = m_pc + 16'd1;
          su   = 1'b1;
        end else begin
          m_pc = m_q.pop_back();
        end
      end else if (c) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          so = 1'b1;
        end
        m_q.push_back(m_pc + 16'd1);
        m_pc = d;
      end else if (l) begin
        m_pc = d;
      end else if (i) begin
        m_pc = m_pc + 16'd1;
      end
    end
    m_ovf = so ? 1'b1 : (e ? 1'b0 : m_ovf);
    m_unf = su ? 1'b1 : (e ? 1'b0 : m_unf);
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, then sample #1 later.
  task automatic drive(input logic h, r, c, l, i, e, input logic [15:0] d);
    hold = h; ret = r; call = c; pcload = l; pcinc = i; err_clr = e; din = d;
    @(posedge clk);
    model_step(h, r, c, l, i, e, d);
    #1;
    {hold, ret, call, pcload, pcinc, err_clr} = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {hold, ret, call, pcload, pcinc, err_clr} = '0;
    din = '0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== {16'h0000, 4'b1000}) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), {16'h0000, 4'b1000});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dout !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_release: dout got %h want 0000", dout);
    end
  endtask

  task automatic test_inc_wrap();
    logic [15:0] want[5];
    want = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, 16'h0);
      n_cmp++;
      if (dout !== want[k] || ras_empty !== 1'b1 || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL inc_%0d: got %h want dout %h (model %h)", k, obs_vec(), want[k], exp_vec());
      end
    end
    drive(0, 0, 0, 1, 0, 0, 16'hFFFE);
    n_cmp++;
    if (dout !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL load_fffe: got %h want fffe", dout);
    end
    for (int k = 3; k < 5; k++) begin
      drive(0, 0, 0, 0, 1, 0, 16'h0);
      n_cmp++;
      if (dout !== want[k] || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL wrap_%0d: got %h want dout %h", k, obs_vec(), want[k]);
      end
    end
  endtask

  task automatic test_nested_call();
    logic [15:0] want[4];
    want = '{16'h0100, 16'h0200, 16'h0101, 16'h0011};
    drive(0, 0, 0, 1, 0, 0, 16'h0010);
    drive(0, 0, 1, 0, 0, 0, 16'h0100);
    n_cmp++;
    if (dout !== want[0] || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL nested_call0: got %h want dout %h", obs_vec(), want[0]);
    end
    drive(0, 0, 1, 0, 0, 0, 16'h0200);
    n_cmp++;
    if (dout !== want[1] || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL nested_call1: got %h want dout %h", obs_vec(), want[1]);
    end
    for (int k = 2; k < 4; k++) begin
      drive(0, 1, 0, 0, 0, 0, 16'h0);
      n_cmp++;
      if (dout !== want[k] || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL nested_ret%0d: got %h want dout %h", k - 2, obs_vec(), want[k]);
      end
    end
    n_cmp++;
    if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
      n_bad++;
      $display("FAIL nested_empty: empty %b unf %b want 1 0", ras_empty, ras_unf);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] want[4];
    want = '{16'h2301, 16'h2201, 16'h2101, 16'h2001};
    drive(0, 0, 0, 1, 0, 0, 16'h1000);
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 0, 0, 0, 16'h2000 + 16'(k * 16'h100));
    n_cmp++;
    if (dout !== 16'h2400 || ras_full !== 1'b1 || ras_ovf !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL ovf_set: got %h want dout 2400 full 1 ovf 1", obs_vec());
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, 0, 0, 16'h0);
      n_cmp++;
      if (dout !== want[k] || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL ovf_ret%0d: got %h want dout %h", k, obs_vec(), want[k]);
      end
    end
    n_cmp++;
    if (ras_empty !== 1'b1 || ras_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: empty %b ovf %b want 1 1", ras_empty, ras_ovf);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0);
    n_cmp++;
    if (ras_ovf !== 1'b0 || dout !== 16'h2001) begin
      n_bad++;
      $display("FAIL ovf_clear: ovf %b dout %h want 0 2001", ras_ovf, dout);
    end
  endtask

  task automatic test_underflow_priority();
    drive(0, 0, 0, 1, 0, 0, 16'h0020);
    drive(0, 1, 0, 0, 0, 0, 16'h0);
    n_cmp++;
    if (dout !== 16'h0021 || ras_unf !== 1'b1 || ras_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL unf_set: got %h want dout 0021 unf 1", obs_vec());
    end
    drive(0, 0, 1, 1, 1, 0, 16'h0300);
    n_cmp++;
    if (dout !== 16'h0300 || ras_empty !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL prio_call: got %h want dout 0300 empty 0", obs_vec());
    end
    drive(1, 1, 1, 1, 1, 0, 16'h0555);
    n_cmp++;
    if (dout !== 16'h0300 || ras_empty !== 1'b0 || ras_unf !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_freeze: got %h want dout 0300 empty 0 unf 1", obs_vec());
    end
    drive(1, 0, 0, 0, 1, 1, 16'h0);
    n_cmp++;
    if (dout !== 16'h0300 || ras_unf !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_errclr: dout %h unf %b want 0300 0", dout, ras_unf);
    end
    drive(0, 1, 0, 0, 0, 0, 16'h0);
    drive(0, 1, 0, 0, 0, 1, 16'h0);
    n_cmp++;
    if (dout !== 16'h0023 || ras_unf !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL set_beats_clear: got %h want dout 0023 unf 1", obs_vec());
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0);
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 0, 0, 0, 16'h0700);
    drive(0, 0, 1, 0, 0, 0, 16'h0800);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== {16'h0000, 4'b1000}) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", obs_vec(), {16'h0000, 4'b1000});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 16'h0);
    n_cmp++;
    if (dout !== 16'h0001 || ras_unf !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_ret: dout %h unf %b want 0001 1", dout, ras_unf);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic h, r, c, l, i, e;
      h = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 4) == 0);
      i = ($urandom_range(0, 1) == 0);
      e = ($urandom_range(0, 7) == 0);
      drive(h, r, c, l, i, e, 16'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_inc_wrap();
    test_nested_call();
    test_overflow();
    test_underflow_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
